regfile_param: RTL and testbench

//  Parametrised flip-flop register file for the pipelined MIPS datapath; the next

---
 rtl/regfile_param.sv | 102 ++++++++++
 tb/tb_regfile_param.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: parametrised flip-flop register file for the pipelined MIPS datapath.
//
// Storage is DEPTH x DATA_WIDTH edge-triggered registers with one write port and
// READ_PORTS independent combinational read ports.
//
// Parameters:
//   DATA_WIDTH  bits per register
//   ADDR_WIDTH  address bits per port
//   DEPTH       registers implemented; legal range 1 .. 2**ADDR_WIDTH
//   READ_PORTS  number of asynchronous read ports (>= 1)
//   ZERO_REG    1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
//
// Ports:
//   clock             in   rising-edge clock, sole clock
//   ctrl_reset_n      in   synchronous active-low reset; clears every register
//   ctrl_writeEnable  in   write strobe, sampled at posedge
//   ctrl_writeReg     in   write address
//   data_writeReg     in   write data
//   ctrl_readReg      in   packed read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   data_readReg      out  packed read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read that matches an accepted write in the
//                      same cycle returns data_writeReg combinationally. Storage
//                      update is identical with or without it.
module regfile_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned READ_PORTS = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                             clock,
    input  logic                             ctrl_reset_n,
    input  logic                             ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]            ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]            data_writeReg,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] ctrl_readReg,
    output logic [READ_PORTS*DATA_WIDTH-1:0] data_readReg
);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // A write is accepted only for an implemented, writable register. Reset is
    // handled in the flop block so that it always wins over a same-edge write.
    logic wr_valid;

    always_comb begin
        wr_valid = ctrl_writeEnable
                   && (32'(ctrl_writeReg) < DEPTH)
                   && !((ZERO_REG != 0) && (ctrl_writeReg == '0));
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_valid && (32'(ctrl_writeReg) == i)) begin
                regs_d[i] = data_writeReg;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : gen_rd_port
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic [DATA_WIDTH-1:0] rd_data;

        assign rd_addr = ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Mux over implemented entries; unimplemented addresses and a hard-wired
        // register 0 fall through to zero.
        always_comb begin
            rd_data = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((32'(rd_addr) == i) && !((ZERO_REG != 0) && (i == 0))) begin
                    rd_data = regs_q[i];
                end
            end
`ifdef REGFILE_BYPASS_EN
            // wr_valid already excludes out-of-range and hard-wired-zero targets.
            if (ctrl_reset_n && wr_valid && (rd_addr == ctrl_writeReg)) begin
                rd_data = data_writeReg;
            end
`endif
        end

        assign data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = rd_data;
    end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // DUT A: default configuration.
    logic        rst_a;
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;

    // DUT B: 16-bit, 24 deep, 4 read ports, ordinary register 0.
    logic        rst_b;
    logic        b_we;
    logic [4:0]  b_waddr;
    logic [15:0] b_wdata;
    logic [19:0] b_raddr;
    logic [63:0] b_rdata;

    regfile_param u_dut_a (
        .clock            (clock),
        .ctrl_reset_n     (rst_a),
        .ctrl_writeEnable (a_we),
        .ctrl_writeReg    (a_waddr),
        .data_writeReg    (a_wdata),
        .ctrl_readReg     (a_raddr),
        .data_readReg     (a_rdata)
    );

    regfile_param #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (5),
        .DEPTH      (24),
        .READ_PORTS (4),
        .ZERO_REG   (0)
    ) u_dut_b (
        .clock            (clock),
        .ctrl_reset_n     (rst_b),
        .ctrl_writeEnable (b_we),
        .ctrl_writeReg    (b_waddr),
        .data_writeReg    (b_wdata),
        .ctrl_readReg     (b_raddr),
        .data_readReg     (b_rdata)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [15:0] model_b [24];

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    task automatic compare(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_check(input string tag, input int p, input logic [4:0] addr,
                           input logic [31:0] exp);
        a_raddr[p*5 +: 5] = addr;
        exp_q.push_back(exp);
        #1;
        compare(tag, a_rdata[p*32 +: 32]);
    endtask

    task automatic b_check(input string tag, input int p, input logic [4:0] addr,
                           input logic [15:0] exp);
        b_raddr[p*5 +: 5] = addr;
        exp_q.push_back({16'h0, exp});
        #1;
        compare(tag, {16'h0, b_rdata[p*16 +: 16]});
    endtask

    task automatic a_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clock);
        a_we    = 1'b1;
        a_waddr = addr;
        a_wdata = data;
        @(posedge clock);
        #1;
        a_we = 1'b0;
    endtask

    task automatic b_write(input logic [4:0] addr, input logic [15:0] data);
        @(negedge clock);
        b_we    = 1'b1;
        b_waddr = addr;
        b_wdata = data;
        @(posedge clock);
        #1;
        b_we = 1'b0;
        if (addr < 5'd24) model_b[addr] = data;
    endtask

    function automatic logic [15:0] b_expect(input logic [4:0] addr);
        logic [15:0] v;
        v = (addr < 5'd24) ? model_b[addr] : 16'h0;
        if (Bypass && rst_b && b_we && (addr == b_waddr) && (addr < 5'd24)) v = b_wdata;
        return v;
    endfunction

    initial begin
        rst_a = 1'b0; a_we = 1'b0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
        rst_b = 1'b0; b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
        for (int i = 0; i < 24; i++) model_b[i] = 16'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Reset state
        a_check("rst_init_a", 0, 5'd9, 32'h0);
        b_check("rst_init_b", 3, 5'd9, 16'h0);

        // Fill, then reset with a competing write on the reset edge
        for (int i = 1; i < 32; i++) a_write(5'(i), 32'hFFFF_FFFF);
        a_check("fill_r1", 0, 5'd1, 32'hFFFF_FFFF);
        a_check("fill_r31", 1, 5'd31, 32'hFFFF_FFFF);
        @(negedge clock);
        rst_a   = 1'b0;
        a_we    = 1'b1;
        a_waddr = 5'd3;
        a_wdata = 32'h0000_1234;
        @(posedge clock);
        #1;
        rst_a = 1'b1;
        a_we  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            for (int p = 0; p < 2; p++) a_check("reset_clear", p, 5'(i), 32'h0);
        end

        // Write / readback
        a_write(5'd5, 32'hDEAD_BEEF);
        a_write(5'd31, 32'h1234_5678);
        a_check("rd_r5_p0", 0, 5'd5, 32'hDEAD_BEEF);
        a_check("rd_r31_p1", 1, 5'd31, 32'h1234_5678);
        a_check("rd_r5_p1", 1, 5'd5, 32'hDEAD_BEEF);
        a_check("rd_r5_p0_again", 0, 5'd5, 32'hDEAD_BEEF);

        // Register 0 behaviour in both configurations
        a_write(5'd0, 32'hA5A5_A5A5);
        a_check("zero_reg_on", 0, 5'd0, 32'h0);
        b_write(5'd0, 16'hA5A5);
        b_check("zero_reg_off", 0, 5'd0, 16'hA5A5);

        // Same-cycle read/write hazard
        a_write(5'd7, 32'h1);
        @(negedge clock);
        a_we    = 1'b1;
        a_waddr = 5'd7;
        a_wdata = 32'h2;
        a_check("hazard_pre", 0, 5'd7, Bypass ? 32'h2 : 32'h1);
        @(posedge clock);
        #1;
        a_we = 1'b0;
        a_check("hazard_post", 0, 5'd7, 32'h2);

        // Out-of-range write on the 24-deep instance
        for (int i = 0; i < 24; i++) b_write(5'(i), 16'(i * 16'h0111 + 1));
        b_write(5'd30, 16'h0055);
        b_check("oor_addr30", 0, 5'd30, 16'h0);
        b_check("oor_addr24", 1, 5'd24, 16'h0);
        for (int i = 0; i < 24; i++) b_check("oor_keep", i % 4, 5'(i), model_b[i]);

        // Random sweep against the model, with occasional reset pulses
        for (int c = 0; c < 10000; c++) begin
            @(negedge clock);
            rst_b   = ($urandom_range(63) != 0);
            b_we    = 1'($urandom_range(1));
            b_waddr = 5'($urandom_range(31));
            b_wdata = 16'($urandom);
            for (int p = 0; p < 4; p++) begin
                b_raddr[p*5 +: 5] = ($urandom_range(3) == 0) ? b_waddr : 5'($urandom_range(31));
            end
            for (int p = 0; p < 4; p++) exp_q.push_back({16'h0, b_expect(b_raddr[p*5 +: 5])});
            #1;
            for (int p = 0; p < 4; p++) compare("sweep", {16'h0, b_rdata[p*16 +: 16]});
            @(posedge clock);
            if (!rst_b) begin
                for (int i = 0; i < 24; i++) model_b[i] = 16'h0;
            end else if (b_we && (b_waddr < 5'd24)) begin
                model_b[b_waddr] = b_wdata;
            end
        end
        #1;
        b_we  = 1'b0;
        rst_b = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
